itch_add_order_encoder: RTL

// Serializes ITCH 5.0 Add Order messages (type 'A', 36 bytes, big-endian) onto a
// 64-bit AXI-Stream master toward the 10GbE MAC or the parser test harness.

---
 rtl/axi_stream_pkg.sv | 37 +++
 rtl/itch_add_order_encoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream widths and ITCH 5.0 Add Order types for the market-data datapath.
package axi_stream_pkg;

  localparam int AXIS_DATA_WIDTH = 64;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  localparam logic [7:0] ITCH_ADD_ORDER     = 8'h41;
  localparam logic [7:0] ITCH_SIDE_BUY      = 8'h42;
  localparam logic [7:0] ITCH_SIDE_SELL     = 8'h53;
  localparam int         ITCH_ADD_ORDER_LEN = 36;

  // side=1 is a sell order, side=0 a buy order
  typedef struct packed {
    logic        valid;
    logic [47:0] timestamp;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } parsed_add_order_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_B3,
    S_B4,
    S_GAP
  } add_order_state_t;

  function automatic logic [7:0] side_code(input logic side);
    return side ? ITCH_SIDE_SELL : ITCH_SIDE_BUY;
  endfunction

endpackage

// File: rtl/itch_add_order_encoder.sv
// Serializes one ITCH Add Order message per accepted order as five 64-bit AXI-Stream beats.
module itch_add_order_encoder
  import axi_stream_pkg::*;
#(
  parameter logic [15:0] TRACKING_INIT = 16'h0000,
  parameter int unsigned IDLE_GAP      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  parsed_add_order_t          in_order,
  input  logic [15:0]                in_locate,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic [63:0]                msg_sent_count
);

  add_order_state_t state;
  logic [15:0] tracking;
  logic [15:0] hold_tracking;
  logic [15:0] hold_locate;
  logic [47:0] hold_ts;
  logic [63:0] hold_ref;
  logic        hold_side;
  logic [31:0] hold_shares;
  logic [63:0] hold_stock;
  logic [31:0] hold_price;
  logic [15:0] gap_cnt;
  logic        accept;
  logic        unused_valid;

  assign unused_valid = in_order.valid;

  // A new order can overlap the B4 handshake only when no idle gap is required
  assign in_ready = rst_n && ((state == S_IDLE) ||
                              ((state == S_B4) && m_axis_tready && (IDLE_GAP == 0)));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      tracking       <= TRACKING_INIT;
      hold_tracking  <= '0;
      hold_locate    <= '0;
      hold_ts        <= '0;
      hold_ref       <= '0;
      hold_side      <= 1'b0;
      hold_shares    <= '0;
      hold_stock     <= '0;
      hold_price     <= '0;
      gap_cnt        <= '0;
      msg_sent_count <= '0;
    end else begin
      if (accept) begin
        hold_tracking <= (state == S_B4) ? tracking + 16'd1 : tracking;
        hold_locate   <= in_locate;
        hold_ts       <= in_order.timestamp;
        hold_ref      <= in_order.order_ref;
        hold_side     <= in_order.side;
        hold_shares   <= in_order.shares;
        hold_stock    <= in_order.stock;
        hold_price    <= in_order.price;
      end
      case (state)
        S_IDLE: if (accept) state <= S_B0;
        S_B0:   if (m_axis_tready) state <= S_B1;
        S_B1:   if (m_axis_tready) state <= S_B2;
        S_B2:   if (m_axis_tready) state <= S_B3;
        S_B3:   if (m_axis_tready) state <= S_B4;
        S_B4: begin
          if (m_axis_tready) begin
            msg_sent_count <= msg_sent_count + 64'd1;
            tracking       <= tracking + 16'd1;
            // The S_IDLE accept cycle is itself one of the idle-gap cycles
            if (accept) begin
              state <= S_B0;
            end else if (IDLE_GAP > 1) begin
              state   <= S_GAP;
              gap_cnt <= 16'(IDLE_GAP - 2);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      S_B0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hFF;
        m_axis_tdata  = {ITCH_ADD_ORDER, hold_locate, hold_tracking, hold_ts[47:24]};
      end
      S_B1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hFF;
        m_axis_tdata  = {hold_ts[23:0], hold_ref[63:24]};
      end
      S_B2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hFF;
        m_axis_tdata  = {hold_ref[23:0], side_code(hold_side), hold_shares};
      end
      S_B3: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hFF;
        m_axis_tdata  = hold_stock;
      end
      S_B4: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = 8'hF0;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = {hold_price, 32'h0};
      end
      default: ;
    endcase
  end

endmodule
